// File: rtl/axi_slv_wr_mem_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : axi_slv_wr_mem_if
// Brief   : AXI write-path signal bundle (AW, W, B) between master and slave.
// Revision: 1.0
// ============================================================================
interface axi_slv_wr_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 16
) ();
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [ID_WIDTH-1:0]     awid;
  logic [1:0]              awburst;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [ID_WIDTH-1:0]     wid;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output awaddr, awid, awburst, awlen, awsize, awvalid,
    input  awready,
    output wdata, wid, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awaddr, awid, awburst, awlen, awsize, awvalid,
    output awready,
    input  wdata, wid, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface
`default_nettype wire

// File: rtl/axi_slv_wr_mem.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : axi_slv_wr_mem
// Brief   : Single-outstanding AXI write slave (FIXED/INCR/WRAP) writing into
//           a byte-strobed internal memory, with a registered debug read port.
// Revision: 1.0
// ============================================================================
module axi_slv_wr_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 16,
  parameter int MEM_DEPTH  = 256
) (
  input  wire logic                         clk,
  input  wire logic                         rst,
  axi_slv_wr_mem_if.slave                   bus,
  input  wire logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
  output logic      [DATA_WIDTH-1:0]        dbg_data
);
  localparam int         c_bytes = DATA_WIDTH / 8;
  localparam int         c_lsb   = $clog2(c_bytes);
  localparam int         c_idxw  = $clog2(MEM_DEPTH);
  localparam logic [1:0] c_fixed = 2'b00;
  localparam logic [1:0] c_wrap  = 2'b10;
  localparam logic [1:0] c_rsvd  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_awready;
  logic                  r_wready;
  logic                  r_bvalid;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_mask;
  logic [1:0]            r_burst;
  logic [7:0]            r_len;
  logic [2:0]            r_size;
  logic [7:0]            r_cnt;
  logic                  r_err;
  logic                  r_burst_err;
  logic [DATA_WIDTH-1:0] r_dbg_data;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_b_hs;
  logic                  w_last_beat;
  logic [ADDR_WIDTH-1:0] w_size_mask;
  logic [ADDR_WIDTH-1:0] w_aw_span;
  logic                  w_wrap_len_ok;
  logic                  w_aw_err;
  logic [ADDR_WIDTH-1:0] w_addr_inc;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic                  w_in_range;
  logic                  w_id_ok;
  logic                  w_last_ok;
  logic                  w_we;
  logic [c_idxw-1:0]     w_idx;

  assign w_aw_hs     = bus.awvalid & r_awready;
  assign w_w_hs      = bus.wvalid & r_wready;
  assign w_b_hs      = r_bvalid & bus.bready;
  assign w_last_beat = (r_cnt == r_len);

  // Burst-level legality, evaluated on the incoming AW payload
  assign w_size_mask   = (ADDR_WIDTH'(1) << bus.awsize) - ADDR_WIDTH'(1);
  assign w_aw_span     = (ADDR_WIDTH'(bus.awlen) + ADDR_WIDTH'(1)) << bus.awsize;
  assign w_wrap_len_ok = (bus.awlen == 8'd1) || (bus.awlen == 8'd3) ||
                         (bus.awlen == 8'd7) || (bus.awlen == 8'd15);
  assign w_aw_err      = (bus.awburst == c_rsvd) ||
                         (bus.awsize > 3'(c_lsb)) ||
                         ((bus.awburst == c_wrap) && !w_wrap_len_ok) ||
                         ((bus.awburst == c_wrap) && ((bus.awaddr & w_size_mask) != '0));

  // Wrapping keeps the bits above the region mask and rolls the bits below it
  assign w_addr_inc = r_addr + (ADDR_WIDTH'(1) << r_size);
  always_comb begin
    w_addr_nxt = w_addr_inc;
    if (r_burst == c_fixed) begin
      w_addr_nxt = r_addr;
    end else if (r_burst == c_wrap) begin
      w_addr_nxt = (r_addr & ~r_mask) | (w_addr_inc & r_mask);
    end
  end

  assign w_in_range = (r_addr >> c_lsb) < ADDR_WIDTH'(MEM_DEPTH);
  assign w_id_ok    = (bus.wid == r_id);
  assign w_last_ok  = (bus.wlast == w_last_beat);
  assign w_we       = w_w_hs && !r_burst_err && w_in_range && w_id_ok && w_last_ok;
  assign w_idx      = r_addr[c_lsb +: c_idxw];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_aw_hs)                w_state_nxt = ST_DATA;
      ST_DATA: if (w_w_hs && w_last_beat)  w_state_nxt = ST_RESP;
      ST_RESP: if (w_b_hs)                 w_state_nxt = ST_IDLE;
      default:                             w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs are registered copies of the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_awready <= (w_state_nxt == ST_IDLE);
      r_wready  <= (w_state_nxt == ST_DATA);
      r_bvalid  <= (w_state_nxt == ST_RESP);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id        <= '0;
      r_addr      <= '0;
      r_mask      <= '0;
      r_burst     <= 2'b00;
      r_len       <= 8'd0;
      r_size      <= 3'd0;
      r_cnt       <= 8'd0;
      r_err       <= 1'b0;
      r_burst_err <= 1'b0;
    end else if (w_aw_hs) begin
      r_id        <= bus.awid;
      r_addr      <= bus.awaddr;
      r_mask      <= w_aw_span - ADDR_WIDTH'(1);
      r_burst     <= bus.awburst;
      r_len       <= bus.awlen;
      r_size      <= bus.awsize;
      r_cnt       <= 8'd0;
      r_err       <= w_aw_err;
      r_burst_err <= w_aw_err;
    end else if (w_w_hs) begin
      r_addr <= w_addr_nxt;
      r_cnt  <= r_cnt + 8'd1;
      if (!w_in_range || !w_id_ok || !w_last_ok) begin
        r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < c_bytes; b++) begin
        if (bus.wstrb[b]) begin
          r_mem[w_idx][b*8 +: 8] <= bus.wdata[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dbg_data <= '0;
    end else begin
      r_dbg_data <= r_mem[dbg_addr];
    end
  end

  assign bus.awready = r_awready;
  assign bus.wready  = r_wready;
  assign bus.bvalid  = r_bvalid;
  assign bus.bid     = r_id;
  assign bus.bresp   = {r_err, 1'b0};
  assign dbg_data    = r_dbg_data;
endmodule
`default_nettype wire

// File: tb/tb_axi_slv_wr_mem.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_axi_slv_wr_mem
// Brief   : Directed self-checking bench for axi_slv_wr_mem.
// Revision: 1.0
// ============================================================================
module tb_axi_slv_wr_mem;
  localparam int c_aw    = 32;
  localparam int c_dw    = 32;
  localparam int c_iw    = 16;
  localparam int c_depth = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  dbg_addr;
  logic [31:0] dbg_data;
  int          n_total = 0;
  int          n_bad   = 0;

  logic [31:0] bd [16];
  logic [3:0]  bs [16];
  logic [15:0] bw [16];
  logic        bl [16];

  logic [1:0]  r_resp;
  logic [15:0] r_bid;

  axi_slv_wr_mem_if #(.ADDR_WIDTH(c_aw), .DATA_WIDTH(c_dw), .ID_WIDTH(c_iw)) bus ();

  axi_slv_wr_mem #(
    .ADDR_WIDTH(c_aw), .DATA_WIDTH(c_dw), .ID_WIDTH(c_iw), .MEM_DEPTH(c_depth)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int n, input logic [31:0] base, input logic [31:0] step,
                      input logic [15:0] id);
    for (int i = 0; i < 16; i++) begin
      bd[i] = base + step * 32'(i);
      bs[i] = 4'hF;
      bw[i] = id;
      bl[i] = (i == n - 1);
    end
  endtask

  task automatic send_aw(input logic [31:0] addr, input logic [15:0] id,
                         input logic [1:0] burst, input logic [7:0] len, input logic [2:0] size);
    int n;
    @(negedge clk);
    bus.awaddr = addr; bus.awid = id; bus.awburst = burst;
    bus.awlen = len; bus.awsize = size; bus.awvalid = 1'b1;
    n = 0;
    while (bus.awready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("awready wait", bus.awready, 1);
    @(posedge clk);
    #1 bus.awvalid = 1'b0;
  endtask

  task automatic send_beats(input int nb);
    int n;
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      bus.wdata = bd[i]; bus.wstrb = bs[i]; bus.wid = bw[i];
      bus.wlast = bl[i]; bus.wvalid = 1'b1;
      n = 0;
      while (bus.wready !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("wready wait beat %0d", i), bus.wready, 1);
      @(posedge clk);
      #1 bus.wvalid = 1'b0;
    end
  endtask

  task automatic get_b(output logic [1:0] resp, output logic [15:0] id);
    int n;
    @(negedge clk);
    bus.bready = 1'b1;
    n = 0;
    while (bus.bvalid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bvalid wait", bus.bvalid, 1);
    resp = bus.bresp;
    id   = bus.bid;
    @(posedge clk);
    #1 bus.bready = 1'b0;
  endtask

  task automatic run_burst(input logic [31:0] addr, input logic [15:0] id, input logic [1:0] burst,
                           input logic [7:0] len, input logic [2:0] size);
    send_aw(addr, id, burst, len, size);
    send_beats(int'(len) + 1);
    get_b(r_resp, r_bid);
  endtask

  task automatic check_word(input string tag, input int idx, input logic [31:0] exp);
    @(negedge clk);
    dbg_addr = 8'(idx);
    @(posedge clk);
    @(negedge clk);
    check(tag, dbg_data, exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.awaddr = '0; bus.awid = '0; bus.awburst = 2'b01; bus.awlen = 8'd0;
    bus.awsize = 3'd2; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wid = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    dbg_addr = 8'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst awready", bus.awready, 0);
    check("rst wready", bus.wready, 0);
    check("rst bvalid", bus.bvalid, 0);
    check("rst bid", bus.bid, 0);
    check("rst bresp", bus.bresp, 0);
    check("rst dbg_data", dbg_data, 0);
    rst = 1'b0;
    #1 check("awready before first edge", bus.awready, 0);
    @(negedge clk);
    check("awready after first edge", bus.awready, 1);

    // Single INCR beat with handshake timing
    fill(1, 32'hDEADBEEF, 32'h0, 16'h5);
    send_aw(32'h10, 16'h5, 2'b01, 8'd0, 3'd2);
    check("wready after aw", bus.wready, 1);
    check("awready after aw", bus.awready, 0);
    send_beats(1);
    check("wready after last", bus.wready, 0);
    check("bvalid after last", bus.bvalid, 1);
    get_b(r_resp, r_bid);
    check("single bresp", r_resp, 2'b00);
    check("single bid", r_bid, 16'h5);
    check("awready after b", bus.awready, 1);
    check_word("single word4", 4, 32'hDEADBEEF);

    // INCR 4 beats with a partial strobe over prefilled ones
    fill(4, 32'hFFFFFFFF, 32'h0, 16'h1);
    run_burst(32'h0, 16'h1, 2'b01, 8'd3, 3'd2);
    fill(4, 32'h12345678, 32'h01010101, 16'h2);
    bs[1] = 4'h3;
    run_burst(32'h0, 16'h2, 2'b01, 8'd3, 3'd2);
    check("incr4 bresp", r_resp, 2'b00);
    check_word("incr4 word0", 0, 32'h12345678);
    check_word("incr4 word1 strobed", 1, 32'hFFFF5779);
    check_word("incr4 word2", 2, 32'h1436587A);
    check_word("incr4 word3", 3, 32'h1537597B);

    // WRAP 4 beats from 0x18: words 6,7,4,5
    fill(4, 32'hC0DE0000, 32'h1, 16'h3);
    run_burst(32'h18, 16'h3, 2'b10, 8'd3, 3'd2);
    check("wrap bresp", r_resp, 2'b00);
    check_word("wrap word6", 6, 32'hC0DE0000);
    check_word("wrap word7", 7, 32'hC0DE0001);
    check_word("wrap word4", 4, 32'hC0DE0002);
    check_word("wrap word5", 5, 32'hC0DE0003);
    fill(4, 32'h99999999, 32'h0, 16'h3);
    run_burst(32'h19, 16'h3, 2'b10, 8'd3, 3'd2);
    check("wrap misaligned bresp", r_resp, 2'b10);
    check_word("wrap misaligned word6", 6, 32'hC0DE0000);
    check_word("wrap misaligned word4", 4, 32'hC0DE0002);

    // Prefill words 8..15 for error cases
    fill(8, 32'h5A5A5A5A, 32'h0, 16'h4);
    run_burst(32'h20, 16'h4, 2'b01, 8'd7, 3'd2);
    check("prefill8 bresp", r_resp, 2'b00);

    fill(1, 32'h11111111, 32'h0, 16'h3);
    run_burst(32'h20, 16'h3, 2'b11, 8'd0, 3'd2);
    check("reserved burst bresp", r_resp, 2'b10);
    check("reserved burst bid", r_bid, 16'h3);
    check_word("reserved burst word8", 8, 32'h5A5A5A5A);

    fill(2, 32'h22220000, 32'h1, 16'h7);
    bw[0] = 16'h8;
    run_burst(32'h24, 16'h7, 2'b01, 8'd1, 3'd2);
    check("wid bresp", r_resp, 2'b10);
    check("wid bid", r_bid, 16'h7);
    check_word("wid word9 dropped", 9, 32'h5A5A5A5A);
    check_word("wid word10 written", 10, 32'h22220001);

    fill(4, 32'h33330000, 32'h1, 16'h1);
    bl[1] = 1'b1;
    run_burst(32'h2C, 16'h1, 2'b01, 8'd3, 3'd2);
    check("wlast early bresp", r_resp, 2'b10);
    check_word("wlast word11", 11, 32'h33330000);
    check_word("wlast word12 dropped", 12, 32'h5A5A5A5A);
    check_word("wlast word13", 13, 32'h33330002);
    check_word("wlast word14", 14, 32'h33330003);

    fill(1, 32'h44444444, 32'h0, 16'h2);
    run_burst(32'h400, 16'h2, 2'b01, 8'd0, 3'd2);
    check("range bresp", r_resp, 2'b10);
    check_word("range word0 untouched", 0, 32'h12345678);

    fill(1, 32'h55555555, 32'h0, 16'h2);
    run_burst(32'h30, 16'h2, 2'b01, 8'd0, 3'd3);
    check("size bresp", r_resp, 2'b10);
    check_word("size word12 untouched", 12, 32'h5A5A5A5A);

    // FIXED burst rewrites one word
    fill(3, 32'h00000600, 32'h1, 16'h6);
    run_burst(32'h50, 16'h6, 2'b00, 8'd2, 3'd2);
    check("fixed bresp", r_resp, 2'b00);
    check_word("fixed word20", 20, 32'h00000602);

    // Response backpressure
    fill(1, 32'h0BADF00D, 32'h0, 16'hA);
    send_aw(32'h40, 16'hA, 2'b01, 8'd0, 3'd2);
    send_beats(1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("bp bvalid %0d", i), bus.bvalid, 1);
      check($sformatf("bp bid %0d", i), bus.bid, 16'hA);
      check($sformatf("bp bresp %0d", i), bus.bresp, 2'b00);
      check($sformatf("bp awready %0d", i), bus.awready, 0);
    end
    get_b(r_resp, r_bid);
    check("bp awready after b", bus.awready, 1);
    check("bp bvalid after b", bus.bvalid, 0);
    check_word("bp word16", 16, 32'h0BADF00D);

    // Reset in the middle of an 8-beat burst
    fill(8, 32'h77777777, 32'h0, 16'h9);
    run_burst(32'h80, 16'h9, 2'b01, 8'd7, 3'd2);
    fill(8, 32'h00000100, 32'h1, 16'h9);
    send_aw(32'h80, 16'h9, 2'b01, 8'd7, 3'd2);
    send_beats(2);
    rst = 1'b1;
    #1;
    check("midrst bvalid", bus.bvalid, 0);
    check("midrst wready", bus.wready, 0);
    check("midrst awready", bus.awready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("midrst awready before edge", bus.awready, 0);
    @(negedge clk);
    check("midrst awready after edge", bus.awready, 1);
    check("midrst bid", bus.bid, 0);
    check_word("midrst word32", 32, 32'h00000100);
    check_word("midrst word33", 33, 32'h00000101);
    for (int i = 34; i < 40; i++) begin
      check_word($sformatf("midrst word%0d", i), i, 32'h77777777);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
